huffman_stream_decoder: RTL and testbench
=========================================

HUFFMAN_STREAM_DECODER -- requirements
Module: huffman_stream_decoder

Interface
REQ-001 Parameter IN_W, default 4: max bits accepted per input beat.
REQ-002 Parameter MAX_CODE, default 9: max codeword length.
REQ-003 Parameter SYM_W, default 4: symbol width, signed.
REQ-004 Parameter NUM_CODES, default 16: codebook entries; index width AW = clog2(NUM_CODES).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 svalid  in  1  input beat valid.
REQ-008 in_bits  in  IN_W  bits in in_bits[in_len-1:0]; bit in_len-1 oldest, bit 0 newest.
REQ-009 in_len  in  clog2(IN_W+1)  valid bit count of beat.
REQ-010 aready  out  1  decoder accepts a beat this cycle.
REQ-011 tvalid  out  1  decoded_symbol valid.
REQ-012 tready  in  1  downstream accepts symbol.
REQ-013 decoded_symbol  out  SYM_W  signed decoded symbol.
REQ-014 cb_we  in  1  codebook write strobe.
REQ-015 cb_addr  in  AW  entry index.
REQ-016 cb_code  in  MAX_CODE  codeword, right-aligned in cb_code[cb_len-1:0], MSB first on the wire.
REQ-017 cb_len  in  clog2(MAX_CODE+1)  codeword length; 0 disables the entry.
REQ-018 cb_sym  in  SYM_W  symbol for entry.
REQ-019 flush  in  1  discard buffered bits.
REQ-020 decode_err  out  1  one-cycle pulse on unmatched prefix.

Function
REQ-021 Bit buffer SHALL be BUF_W = MAX_CODE+IN_W bits with a bit_count register, oldest bit first.
REQ-022 aready SHALL be 1 iff bit_count <= BUF_W-IN_W, flush is 0, and state is not ERR.
REQ-023 Beat accepted on svalid&&aready; in_len 0 is a no-op; in_len > IN_W is clamped to IN_W.
REQ-024 Entry i matches iff cb_len_i >= 1, cb_len_i <= bit_count, and the oldest cb_len_i buffered bits equal cb_code_i[cb_len_i-1:0]; lowest matching index wins.
REQ-025 States: RUN (no symbol held or tready=1), STALL (tvalid=1, tready=0), ERR (one cycle).
REQ-026 In RUN with a match: the symbol is registered to decoded_symbol, tvalid is set next cycle, and cb_len bits are consumed in the same cycle.
REQ-027 In STALL: no consumption; decoded_symbol and tvalid are held; input acceptance continues per REQ-022.
REQ-028 Symbol transfer occurs on tvalid&&tready; tvalid drops next cycle unless a new match loads.
REQ-029 Back-to-back: one symbol per cycle while matches exist and tready=1.
REQ-030 Latency: a symbol completed by an accepted beat is valid on the cycle after the next edge (accept edge, then decode edge).
REQ-031 Simultaneous accept and consume: bit_count_next = bit_count - consumed + accepted; consumption uses pre-accept bits.
REQ-032 No match with bit_count >= MAX_CODE: enter ERR, pulse decode_err, drop the single oldest bit, then return to RUN.
REQ-033 A codebook write takes effect from the next cycle; a decode in the write cycle uses the old contents.
REQ-034 flush SHALL clear bit_count and force state to RUN; a held tvalid symbol is preserved.

Reset
REQ-035 On reset low, asynchronously: bit_count=0, state=RUN, tvalid=0, decoded_symbol=0, decode_err=0, aready=0 while reset is asserted, all cb_len=0.
REQ-036 Reset release SHALL be synchronised so that aready first rises on the second clk edge after deassertion.
REQ-037 Reset asserted mid-symbol SHALL drop buffered bits and any held symbol without emitting it.

Configuration
REQ-038 With HUFF_STATS_EN defined: outputs sym_count (16 b, +1 per tvalid&&tready, wraps) and err_count (8 b, +1 per decode_err, saturates at 255), both cleared by reset.
REQ-039 Without HUFF_STATS_EN: these ports and their counters are absent.

Verification
Codebook used below: e0 code 0 len 1 sym 0; e1 code 10 len 2 sym 1; e2 code 110 len 3 sym -1; e3 code 111 len 3 sym 2.
REQ-040 Beat 4'b0101, len 4, tready=1 -> symbols 0, 1 on consecutive cycles; bit_count=1 remains.
REQ-041 Follow REQ-040 with beat 2'b10 -> buffer holds 110 -> symbol -1 (4'hF).
REQ-042 Hold tready=0 with 9+ bits queued -> tvalid stays 1, symbol stable, aready drops at bit_count > BUF_W-IN_W; release tready -> decoding resumes, no loss.
REQ-043 Only e1 programmed, stream 9 ones -> one decode_err pulse per dropped bit; err_count increments when HUFF_STATS_EN is defined.
REQ-044 Rewrite e0 to sym 5 while decoding a 0 stream -> old symbol 0 emitted in the write cycle, 5 from the next cycle.
REQ-045 Reset asserted while in STALL -> tvalid=0 and bit_count=0 immediately; after release, no stale symbol is emitted.

Source files
------------

// File: rtl/huffman_stream_decoder_if.sv
// Handshake, codebook-programming and status bundle for huffman_stream_decoder.
// master = stream source / controller side, slave = decoder side.
interface huffman_stream_decoder_if #(
  parameter int IN_W      = 4,
  parameter int MAX_CODE  = 9,
  parameter int SYM_W     = 4,
  parameter int NUM_CODES = 16
);
  localparam int AW  = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
  localparam int LW  = $clog2(IN_W + 1);
  localparam int CLW = $clog2(MAX_CODE + 1);

  logic                    svalid;
  logic [IN_W-1:0]         in_bits;
  logic [LW-1:0]           in_len;
  logic                    aready;
  logic                    tvalid;
  logic                    tready;
  logic signed [SYM_W-1:0] decoded_symbol;
  logic                    cb_we;
  logic [AW-1:0]           cb_addr;
  logic [MAX_CODE-1:0]     cb_code;
  logic [CLW-1:0]          cb_len;
  logic signed [SYM_W-1:0] cb_sym;
  logic                    flush;
  logic                    decode_err;

  modport master (
    output svalid, in_bits, in_len, tready, cb_we, cb_addr, cb_code, cb_len, cb_sym, flush,
    input  aready, tvalid, decoded_symbol, decode_err
  );

  modport slave (
    input  svalid, in_bits, in_len, tready, cb_we, cb_addr, cb_code, cb_len, cb_sym, flush,
    output aready, tvalid, decoded_symbol, decode_err
  );
endinterface

// File: rtl/huffman_stream_decoder.sv
// Programmable-codebook prefix decoder: buffers a bit stream and emits one symbol per match.
// Define HUFF_STATS_EN to add the sym_count / err_count statistics outputs.
module huffman_stream_decoder #(
  parameter int IN_W      = 4,
  parameter int MAX_CODE  = 9,
  parameter int SYM_W     = 4,
  parameter int NUM_CODES = 16
) (
  input  logic clk,
  input  logic reset,
  huffman_stream_decoder_if.slave bus
`ifdef HUFF_STATS_EN
  ,
  output logic [15:0] sym_count,
  output logic [7:0]  err_count
`endif
);
  localparam int AW    = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
  localparam int LW    = $clog2(IN_W + 1);
  localparam int CLW   = $clog2(MAX_CODE + 1);
  localparam int BUF_W = MAX_CODE + IN_W;
  localparam int CW    = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_ERR = 2'd2} state_t;

  state_t                  state_r, state_nxt_s;
  logic [BUF_W-1:0]        buf_r, buf_nxt_s, beat_s;
  logic [CW-1:0]           bit_count_r, bit_count_nxt_s, rem_s, cons_s;
  logic                    tvalid_r, tvalid_nxt_s;
  logic signed [SYM_W-1:0] sym_r, sym_nxt_s;
  logic                    decode_err_r, err_nxt_s;
  logic [1:0]              rst_sync_r;
  logic                    aready_s, acc_s;
  logic [LW-1:0]           acc_len_s;
  logic                    match_s;
  logic [CLW-1:0]          match_len_s;
  logic signed [SYM_W-1:0] match_sym_s;

  logic [MAX_CODE-1:0]     cb_code_r [NUM_CODES];
  logic [CLW-1:0]          cb_len_r  [NUM_CODES];
  logic signed [SYM_W-1:0] cb_sym_r  [NUM_CODES];

  function automatic logic [MAX_CODE-1:0] code_mask(input logic [CLW-1:0] len);
    code_mask = {MAX_CODE{1'b1}} >> (MAX_CODE - int'(len));
  endfunction

  function automatic logic [IN_W-1:0] beat_mask(input logic [LW-1:0] len);
    beat_mask = {IN_W{1'b1}} >> (IN_W - int'(len));
  endfunction

  // Oldest buffered bit sits at buf_r[BUF_W-1]; unused low bits are kept zero.
  assign aready_s   = rst_sync_r[1] && (bit_count_r <= CW'(BUF_W - IN_W)) &&
                      !bus.flush && (state_r != ST_ERR);
  assign acc_s      = bus.svalid && aready_s;
  assign acc_len_s  = (bus.in_len > LW'(IN_W)) ? LW'(IN_W) : bus.in_len;

  assign bus.aready         = aready_s;
  assign bus.tvalid         = tvalid_r;
  assign bus.decoded_symbol = sym_r;
  assign bus.decode_err     = decode_err_r;

  // Codebook lookup over the pre-accept buffer; lowest matching index wins
  always_comb begin
    match_s     = 1'b0;
    match_len_s = '0;
    match_sym_s = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if ((cb_len_r[i] != '0) && (cb_len_r[i] <= CLW'(MAX_CODE)) &&
          (CW'(cb_len_r[i]) <= bit_count_r) &&
          ((buf_r >> (BUF_W - int'(cb_len_r[i]))) ==
           BUF_W'(cb_code_r[i] & code_mask(cb_len_r[i])))) begin
        match_s     = 1'b1;
        match_len_s = cb_len_r[i];
        match_sym_s = cb_sym_r[i];
      end else begin
        match_s     = match_s;
      end
    end
  end

  // Decode control: STALL means a symbol is held; tready lets it behave like RUN
  always_comb begin
    state_nxt_s  = state_r;
    tvalid_nxt_s = tvalid_r;
    sym_nxt_s    = sym_r;
    err_nxt_s    = 1'b0;
    cons_s       = '0;
    case (state_r)
      ST_RUN, ST_STALL: begin
        if (bus.flush || (tvalid_r && !bus.tready)) begin
          if (tvalid_r && !bus.tready) begin
            state_nxt_s  = ST_STALL;
            tvalid_nxt_s = 1'b1;
          end else begin
            state_nxt_s  = ST_RUN;
            tvalid_nxt_s = 1'b0;
          end
        end else if (match_s) begin
          state_nxt_s  = ST_STALL;
          tvalid_nxt_s = 1'b1;
          sym_nxt_s    = match_sym_s;
          cons_s       = CW'(match_len_s);
        end else if (bit_count_r >= CW'(MAX_CODE)) begin
          state_nxt_s  = ST_ERR;
          tvalid_nxt_s = 1'b0;
          err_nxt_s    = 1'b1;
        end else begin
          state_nxt_s  = ST_RUN;
          tvalid_nxt_s = 1'b0;
        end
      end
      ST_ERR: begin
        state_nxt_s  = ST_RUN;
        tvalid_nxt_s = 1'b0;
        if (bus.flush) begin
          cons_s = '0;
        end else begin
          cons_s = CW'(1);
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        tvalid_nxt_s = 1'b0;
      end
    endcase
  end

  // Buffer update: consume from the old contents, then append the accepted beat behind what remains
  always_comb begin
    rem_s           = bit_count_r - cons_s;
    beat_s          = BUF_W'(bus.in_bits & beat_mask(acc_len_s));
    buf_nxt_s       = buf_r << cons_s;
    bit_count_nxt_s = rem_s;
    if (bus.flush) begin
      buf_nxt_s       = '0;
      bit_count_nxt_s = '0;
    end else if (acc_s) begin
      buf_nxt_s       = buf_nxt_s | (beat_s << (BUF_W - int'(rem_s) - int'(acc_len_s)));
      bit_count_nxt_s = rem_s + CW'(acc_len_s);
    end else begin
      bit_count_nxt_s = rem_s;
    end
  end

  // Reset-release synchroniser gating input acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Datapath and handshake state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_RUN;
      buf_r        <= '0;
      bit_count_r  <= '0;
      tvalid_r     <= 1'b0;
      sym_r        <= '0;
      decode_err_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      buf_r        <= buf_nxt_s;
      bit_count_r  <= bit_count_nxt_s;
      tvalid_r     <= tvalid_nxt_s;
      sym_r        <= sym_nxt_s;
      decode_err_r <= err_nxt_s;
    end
  end

  // Codebook storage; a write becomes visible to matching on the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        cb_code_r[i] <= '0;
        cb_len_r[i]  <= '0;
        cb_sym_r[i]  <= '0;
      end
    end else if (bus.cb_we) begin
      cb_code_r[bus.cb_addr] <= bus.cb_code;
      cb_len_r[bus.cb_addr]  <= bus.cb_len;
      cb_sym_r[bus.cb_addr]  <= bus.cb_sym;
    end
  end

`ifdef HUFF_STATS_EN
  // Statistics: wrapping transfer count, saturating error count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_count <= 16'd0;
      err_count <= 8'd0;
    end else begin
      if (tvalid_r && bus.tready) begin
        sym_count <= sym_count + 16'd1;
      end
      if (decode_err_r && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_huffman_stream_decoder.sv
// Self-checking bench for huffman_stream_decoder: bit-queue reference model checked every cycle,
// plus literal expectations for the documented decode scenarios.
module tb_huffman_stream_decoder;
  localparam int IN_W      = 4;
  localparam int MAX_CODE  = 9;
  localparam int SYM_W     = 4;
  localparam int NUM_CODES = 16;
  localparam int BUF_W     = MAX_CODE + IN_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_stream_decoder_if #(.IN_W(IN_W), .MAX_CODE(MAX_CODE), .SYM_W(SYM_W),
                              .NUM_CODES(NUM_CODES)) bus ();
`ifdef HUFF_STATS_EN
  logic [15:0] sym_count;
  logic [7:0]  err_count;
`endif

  huffman_stream_decoder #(.IN_W(IN_W), .MAX_CODE(MAX_CODE), .SYM_W(SYM_W),
                           .NUM_CODES(NUM_CODES)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef HUFF_STATS_EN
    .sym_count (sym_count),
    .err_count (err_count),
`endif
    .bus   (bus)
  );

  // Reference model state: buffered bits as a queue, oldest at index 0
  bit                  m_bits[$];
  int                  m_code [NUM_CODES];
  int                  m_len  [NUM_CODES];
  logic [SYM_W-1:0]    m_csym [NUM_CODES];
  logic                m_tvalid, m_err, m_in_err;
  logic [SYM_W-1:0]    m_sym;
  int                  m_sync, m_symcnt, m_errcnt;
  int                  n_pass = 0, n_total = 0;
  int                  xfers = 0, errs = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_tvalid = 1'b0; m_err = 1'b0; m_in_err = 1'b0; m_sym = '0;
    m_sync = 0; m_symcnt = 0; m_errcnt = 0;
    for (int i = 0; i < NUM_CODES; i++) begin
      m_code[i] = 0; m_len[i] = 0; m_csym[i] = '0;
    end
  endtask

  function automatic int find_match();
    bit ok;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (m_len[i] >= 1 && m_len[i] <= MAX_CODE && m_len[i] <= m_bits.size()) begin
        ok = 1'b1;
        for (int k = 0; k < m_len[i]; k++)
          if (((m_code[i] >> (m_len[i] - 1 - k)) & 1) != int'(m_bits[k])) ok = 1'b0;
        if (ok) return i;
      end
    end
    return -1;
  endfunction

  // One clock cycle: check aready before the edge, advance the model, check registered outputs after
  task automatic cyc();
    bit   nb[$];
    bit   dropped;
    logic nv, ne, ni, exp_rdy, acc;
    logic [SYM_W-1:0] ns;
    int   idx, ln, ib;
    #1;
    exp_rdy = reset && (m_sync >= 2) && (m_bits.size() <= BUF_W - IN_W) &&
              !bus.flush && !m_in_err;
    chk("aready", 32'(bus.aready), 32'(exp_rdy));
    acc = bus.svalid && exp_rdy;
    if (bus.tvalid && bus.tready) xfers++;
    nb = m_bits; nv = m_tvalid; ns = m_sym; ne = 1'b0; ni = 1'b0;
    if (m_in_err) begin
      nv = 1'b0;
      if (!bus.flush) dropped = nb.pop_front();
    end else if (bus.flush || (m_tvalid && !bus.tready)) begin
      nv = m_tvalid && !bus.tready;
    end else begin
      idx = find_match();
      if (idx >= 0) begin
        ns = m_csym[idx]; nv = 1'b1;
        for (int k = 0; k < m_len[idx]; k++) dropped = nb.pop_front();
      end else if (m_bits.size() >= MAX_CODE) begin
        ni = 1'b1; ne = 1'b1; nv = 1'b0;
      end else begin
        nv = 1'b0;
      end
    end
    if (bus.flush) nb.delete();
    else if (acc) begin
      ln = (int'(bus.in_len) > IN_W) ? IN_W : int'(bus.in_len);
      ib = int'(bus.in_bits);
      for (int k = ln - 1; k >= 0; k--) nb.push_back(((ib >> k) & 1) != 0);
    end
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else begin
      if (m_tvalid && bus.tready) m_symcnt = (m_symcnt + 1) % 65536;
      if (m_err && m_errcnt < 255) m_errcnt++;
      if (bus.cb_we) begin
        m_code[bus.cb_addr] = int'(bus.cb_code);
        m_len[bus.cb_addr]  = int'(bus.cb_len);
        m_csym[bus.cb_addr] = bus.cb_sym;
      end
      m_bits = nb; m_tvalid = nv; m_sym = ns; m_err = ne; m_in_err = ni;
      if (m_sync < 2) m_sync++;
    end
    if (bus.decode_err) errs++;
    chk("tvalid", 32'(bus.tvalid), 32'(m_tvalid));
    if (m_tvalid) chk("symbol", 32'({bus.decoded_symbol}), 32'(m_sym));
    chk("decode_err", 32'(bus.decode_err), 32'(m_err));
`ifdef HUFF_STATS_EN
    chk("sym_count", 32'(sym_count), 32'(m_symcnt));
    chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic beat(input logic [3:0] b, input logic [2:0] l);
    bus.svalid = 1'b1; bus.in_bits = b; bus.in_len = l;
  endtask

  task automatic idle();
    bus.svalid = 1'b0; bus.in_bits = 4'd0; bus.in_len = 3'd0;
  endtask

  task automatic cb_write(input logic [3:0] a, input logic [8:0] c, input logic [3:0] l,
                          input logic [3:0] s);
    bus.cb_we = 1'b1; bus.cb_addr = a; bus.cb_code = c; bus.cb_len = l; bus.cb_sym = s;
    cyc();
    bus.cb_we = 1'b0;
  endtask

  initial begin
    idle();
    bus.tready = 1'b0; bus.flush = 1'b0; bus.cb_we = 1'b0;
    bus.cb_addr = 4'd0; bus.cb_code = 9'd0; bus.cb_len = 4'd0; bus.cb_sym = 4'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_tvalid", 32'(bus.tvalid), 32'd0);
    chk("rst_aready", 32'(bus.aready), 32'd0);
    chk("rst_err", 32'(bus.decode_err), 32'd0);
    chk("rst_sym", 32'({bus.decoded_symbol}), 32'd0);
    run(2);
    reset = 1'b1;
    cyc();
    chk("aready_edge1", 32'(bus.aready), 32'd0);
    cyc();
    chk("aready_edge2", 32'(bus.aready), 32'd1);

    // Codebook: 0 ->0, 10 ->1, 110 -> -1, 111 ->2
    cb_write(4'd0, 9'b0,   4'd1, 4'd0);
    cb_write(4'd1, 9'b10,  4'd2, 4'd1);
    cb_write(4'd2, 9'b110, 4'd3, 4'hF);
    cb_write(4'd3, 9'b111, 4'd3, 4'd2);

    // 0101 -> 0, 1 with one bit left; then 10 completes 110 -> -1
    bus.tready = 1'b1;
    beat(4'b0101, 3'd4); cyc(); idle();
    cyc(); chk("s040_v0", 32'(bus.tvalid), 32'd1); chk("s040_sym0", 32'({bus.decoded_symbol}), 32'd0);
    cyc(); chk("s040_sym1", 32'({bus.decoded_symbol}), 32'd1);
    cyc(); chk("s040_drop", 32'(bus.tvalid), 32'd0); chk("s040_left", 32'(m_bits.size()), 32'd1);
    beat(4'b0010, 3'd2); cyc(); idle();
    cyc(); chk("s041_sym", 32'({bus.decoded_symbol}), 32'hF);
    cyc(); chk("s041_left", 32'(m_bits.size()), 32'd0);

    // in_len 7 clamps to 4 (1110 -> 2, 0), then an in_len 0 beat is a no-op
    beat(4'b1110, 3'd7); cyc();
    beat(4'b1111, 3'd0); cyc(); idle();
    chk("clamp_sym2", 32'({bus.decoded_symbol}), 32'd2);
    cyc(); chk("clamp_sym0", 32'({bus.decoded_symbol}), 32'd0);
    cyc(); chk("clamp_left", 32'(m_bits.size()), 32'd0);

    // Backpressure: symbol held, aready drops above 9 buffered bits, no loss on release
    xfers = 0;
    bus.tready = 1'b0;
    beat(4'b1010, 3'd4); run(3);
    chk("stall_aready", 32'(bus.aready), 32'd0);
    chk("stall_bits", 32'(m_bits.size()), 32'd10);
    run(2);
    chk("stall_v", 32'(bus.tvalid), 32'd1);
    chk("stall_sym", 32'({bus.decoded_symbol}), 32'd1);
    idle(); bus.tready = 1'b1; run(8);
    chk("stall_xfers", 32'(xfers), 32'd6);

    // Rewrite e0 to symbol 5 in the middle of a zero stream
    beat(4'b0000, 3'd4); run(2);
    cb_write(4'd0, 9'b0, 4'd1, 4'd5);
    chk("cbw_old", 32'({bus.decoded_symbol}), 32'd0);
    cyc(); chk("cbw_new", 32'({bus.decoded_symbol}), 32'd5);
    idle(); bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    chk("flush_bits", 32'(m_bits.size()), 32'd0);
    cyc(); chk("flush_v", 32'(bus.tvalid), 32'd0);

    // Only e1 left: 12 ones -> four error pulses down to 8 bits
    cb_write(4'd0, 9'b0, 4'd0, 4'd0);
    cb_write(4'd2, 9'b0, 4'd0, 4'd0);
    cb_write(4'd3, 9'b0, 4'd0, 4'd0);
    errs = 0;
    beat(4'b1111, 3'd4); run(3); idle(); run(12);
    chk("err_pulses", 32'(errs), 32'd4);
    chk("err_left", 32'(m_bits.size()), 32'd8);
`ifdef HUFF_STATS_EN
    chk("err_count_lit", 32'(err_count), 32'd4);
`endif

    // Reset during STALL drops the held symbol immediately and for good
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    bus.tready = 1'b0;
    beat(4'b1010, 3'd4); cyc(); idle(); run(2);
    chk("pre_rst_v", 32'(bus.tvalid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_v", 32'(bus.tvalid), 32'd0);
    chk("mid_rst_aready", 32'(bus.aready), 32'd0);
    model_reset();
    cyc();
    reset = 1'b1; bus.tready = 1'b1; xfers = 0;
    run(6);
    chk("post_rst_xfers", 32'(xfers), 32'd0);
    chk("post_rst_v", 32'(bus.tvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
